// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback (priority)
// and a FIFO-buffered long-latency unit, with a busy scoreboard and a starvation stall.
module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    a_we,
  input  logic [4:0]              a_wn,
  input  logic [31:0]             a_d,
  input  logic                    b_valid,
  input  logic [4:0]              b_wn,
  input  logic [31:0]             b_d,
  output logic                    b_ready,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_wn,
  input  logic [4:0]              rna,
  input  logic [4:0]              rnb,
  output logic                    hz_a,
  output logic                    hz_b,
  output logic                    stall_pipe,
  output logic                    rf_we,
  output logic [4:0]              rf_wn,
  output logic [31:0]             rf_d,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    r_wn [DEPTH];
  logic [31:0]   r_d  [DEPTH];
  logic [AW-1:0] r_rp, r_wp;
  logic [AW:0]   r_cnt;
  logic [31:0]   r_busy;
  logic [SW-1:0] r_starve;
  logic          w_a_win, w_ne, w_pop, w_push;
  logic [31:0]   w_set, w_clr;
  assign w_a_win    = a_we && a_wn != 5'd0;
  assign w_ne       = r_cnt != '0;
  assign w_pop      = !w_a_win && w_ne;
  assign b_ready    = r_cnt < (AW+1)'(DEPTH);
  assign w_push     = b_valid && b_ready && b_wn != 5'd0;
  assign rf_we      = clrn && (w_a_win || w_ne);
  assign rf_wn      = w_a_win ? a_wn : w_ne ? r_wn[r_rp] : 5'd0;
  assign rf_d       = w_a_win ? a_d : w_ne ? r_d[r_rp] : 32'd0;
  assign fifo_cnt   = r_cnt;
  assign stall_pipe = r_starve == SW'(STARVE_MAX);
  assign hz_a       = rna != 5'd0 && r_busy[rna];
  assign hz_b       = rnb != 5'd0 && r_busy[rnb];
  assign w_set      = 32'(iss_valid && iss_wn != 5'd0) << iss_wn;
  assign w_clr      = 32'(w_pop) << r_wn[r_rp];
  always_ff @(posedge clk)
    if (w_push) begin
      r_wn[r_wp] <= b_wn;
      r_d[r_wp]  <= b_d;
    end
  // clear before set so a re-issue of the register being retired stays busy
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_rp     <= '0;
      r_wp     <= '0;
      r_cnt    <= '0;
      r_busy   <= '0;
      r_starve <= '0;
    end else begin
      r_rp     <= r_rp + AW'(w_pop);
      r_wp     <= r_wp + AW'(w_push);
      r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_busy   <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
      r_starve <= (w_ne && w_a_win) ? (stall_pipe ? r_starve : r_starve + SW'(1)) : '0;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-port controller for the 32x32 register file (two async read ports, one write port written on negedge clk, r0 hardwired zero). Shares the single write port between the in-order pipeline writeback (port A, fixed priority, never stalled) and a long-latency unit such as mul/div (port B, valid/ready, buffered in a small FIFO). Keeps a per-register busy scoreboard so decode can detect RAW hazards on outstanding long-latency results. Forces a pipeline bubble when port B starves.

Parameters:
DEPTH, 4, port-B FIFO entries (power of 2, >=2)
STARVE_MAX, 3, consecutive cycles FIFO may be non-empty and lose the port before stall_pipe is raised

Ports:
clk  in  1  clock; arbiter state updates on posedge
clrn  in  1  reset, asynchronous, active-low
a_we  in  1  pipeline writeback enable
a_wn  in  5  pipeline destination register
a_d  in  32  pipeline writeback data
b_valid  in  1  long-latency result valid
b_wn  in  5  long-latency destination register
b_d  in  32  long-latency result data
b_ready  out  1  FIFO can accept a port-B result
iss_valid  in  1  long-latency op issued this cycle
iss_wn  in  5  destination of issued op
rna, rnb  in  5  decode source registers to check
hz_a, hz_b  out  1  source rna/rnb has an outstanding long-latency write
stall_pipe  out  1  pipeline must insert a bubble (a_we=0) this cycle
rf_we, rf_wn, rf_d  out  1/5/32  to register file we/wn/d
fifo_cnt  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (clrn=0, async): FIFO emptied (contents discarded), fifo_cnt=0, busy[31:1]=0, starve counter=0, stall_pipe=0. rf_we forced 0 while clrn=0. b_ready=1, hz_a/hz_b=0 immediately after reset. Reset mid-operation drops all queued results and all hazards.
- Port select (combinational, stable posedge to posedge so the negedge write captures it):
  - A wins if a_we=1 and a_wn!=0: rf_we=1, rf_wn=a_wn, rf_d=a_d.
  - Else, if FIFO non-empty: head entry drives the port, rf_we=1.
  - Else rf_we=0, rf_wn=0, rf_d=0.
  - a_we with a_wn=0 is treated as no request; the port goes to the FIFO.
- FIFO:
  - b_ready = (fifo_cnt<DEPTH), with no bypass to the port.
  - Push at posedge when b_valid&&b_ready&&b_wn!=0. b_valid with b_wn=0 is handshaken and dropped.
  - Pop at posedge ending a cycle in which the head drove the port.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - Full: b_ready=0; the producer holds b_valid/b_wn/b_d.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - busy[iss_wn] set at posedge when iss_valid&&iss_wn!=0.
  - busy[head.wn] cleared at the posedge ending the cycle the head is written.
  - Set and clear of the same register in the same cycle: set wins.
  - hz_a = (rna!=0)&&busy[rna]; hz_b likewise; both combinational.
  - Because the regfile writes at negedge, the value is readable in the cycle after busy clears.
- Starvation:
  - Counter increments at posedge when FIFO is non-empty and A wins; it resets when the FIFO wins or becomes empty.
  - stall_pipe = registered (counter==STARVE_MAX), so it is high for exactly the next cycle, then the counter clears.
  - Contract: pipeline drives a_we=0 when stall_pipe=1. If a_we=1 anyway, A still wins (fixed priority) and the counter saturates, so stall_pipe stays high.
- No combinational path from b_valid to b_ready.

Test Plan:
- Reset then idle: rf_we=0, b_ready=1, fifo_cnt=0, hz_a=hz_b=0; assert clrn=0 mid-run with 3 entries queued -> fifo_cnt=0 and busy cleared at once, no further rf_we from the old entries.
- A only, a_we=1 a_wn=5 a_d=0x12345678 -> same cycle rf_we=1 rf_wn=5 rf_d=0x12345678; a_wn=0 -> rf_we=0.
- iss_valid wn=7 at cycle 0; B result wn=7 d=0xDEADBEEF with A idle -> hz_a=1 (rna=7) from cycle 1 until the FIFO write cycle; rf_wn=7 rf_d=0xDEADBEEF; hz_a=0 the next cycle.
- A busy every cycle, push 5 B results -> 4 accepted, b_ready=0 with fifo_cnt=4; stall_pipe=1 after 3 losing cycles; with a_we=0 that cycle the head is written and fifo_cnt=3.
- Same cycle: iss_valid wn=9 while head wn=9 is written -> busy[9] remains 1.
- Simultaneous push and pop with fifo_cnt=2 -> fifo_cnt stays 2, FIFO order preserved across pointer wrap (8+ entries streamed, written in order).
